seg_display_fmt: RTL and testbench

SEG_DISPLAY_FMT -- requirements
Module: seg_display_fmt

---
 rtl/types_pkg.sv | 41 ++++
 rtl/bcd_seq_conv.sv | 77 +++++++
 rtl/seg_display_fmt.sv | 193 +++++++++++++++++++
 tb/tb_seg_display_fmt.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types and constants for the seven-segment display formatter.
//   DIGITS      : default number of displayed digits
//   word_t      : 32-bit data word
//   byte_t      : one cathode byte (active low, bit 7 = dp, bit 6 = g ... bit 0 = a)
//   SEG_*       : special glyphs
//   dec_cat_map : per-digit nibble-to-cathode decoder
package types_pkg;

  localparam int DIGITS = 8;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam byte_t SEG_BLANK = 8'hFF;
  localparam byte_t SEG_MINUS = 8'hBF;
  localparam byte_t SEG_E     = 8'h86;

  function automatic byte_t dec_cat_map(input logic [3:0] nib);
    byte_t c;
    case (nib)
      4'h0: c = 8'hC0;
      4'h1: c = 8'hF9;
      4'h2: c = 8'hA4;
      4'h3: c = 8'hB0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hF8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h90;
      4'hA: c = 8'h88;
      4'hB: c = 8'h83;
      4'hC: c = 8'hC6;
      4'hD: c = 8'hA1;
      4'hE: c = 8'h86;
      default: c = 8'h8E;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Iterative binary-to-BCD converter (double dabble), one bit per cycle.
//   clk, rst : clock, synchronous active-high reset (aborts a conversion)
//   start    : load bin and begin; takes priority over a running conversion
//   bin      : unsigned binary input, sampled on start
//   busy     : conversion steps remaining
//   done     : one-cycle pulse after the last step; bcd is valid and held
//   bcd      : NBCD packed BCD digits, digit 0 in bits [3:0]
module bcd_seq_conv #(
  parameter int WIDTH = 32,
  parameter int NBCD  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [NBCD*4-1:0] bcd
);

  localparam int CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  sh_q, sh_d;
  logic [NBCD*4-1:0] bcd_q, bcd_d;
  logic [NBCD*4-1:0] adj;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  function automatic logic [NBCD*4-1:0] add3(input logic [NBCD*4-1:0] b);
    logic [NBCD*4-1:0] r;
    r = b;
    for (int i = 0; i < NBCD; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    adj    = add3(bcd_q);
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CNTW'(WIDTH);
    end else if (cnt_q != '0) begin
      // Correct every digit, then shift the next binary MSB into the BCD LSB.
      // NBCD carries one spare digit, so the bit shifted out of adj is always 0.
      bcd_d  = (adj << 1) | {{(NBCD*4-1){1'b0}}, sh_q[WIDTH-1]};
      sh_d   = sh_q << 1;
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CNTW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q  <= sh_d;
    bcd_q <= bcd_d;
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_fmt.sv
// Signed value to seven-segment formatter with leading-zero blanking,
// sign placement, overflow indication and edit-digit blinking.
//   clk, rst    : clock, synchronous active-high reset
//   value       : signed value to show, taken when value_valid is high
//   value_valid : one-cycle request; while busy it lands in a one-deep pending slot
//   is_edit     : blink digit edit_pos at the blink rate
//   edit_pos    : digit to blink, 0 = rightmost
//   blank_lz    : leading-zero blanking, sampled when the result is formatted
//   display     : cathode byte per digit, digit i at [i*8 +: 8]
//   busy        : high whenever not idle
//   done        : one-cycle pulse when display takes a new result
module seg_display_fmt #(
  parameter int DIGITS    = types_pkg::DIGITS,
  parameter int WIDTH     = 32,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   value,
  input  logic                      value_valid,
  input  logic                      is_edit,
  input  logic [$clog2(DIGITS)-1:0] edit_pos,
  input  logic                      blank_lz,
  output logic [DIGITS*8-1:0]       display,
  output logic                      busy,
  output logic                      done
);

  import types_pkg::*;

  // One spare digit beyond ceil(WIDTH*log10(2)) keeps the add-3 shift lossless.
  localparam int NBCD = (WIDTH * 30103 + 99999) / 100000 + 1;
  localparam int NPAD = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int CW   = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_FMT} state_e;

  state_e                   state_q, state_d;
  logic                     pend_vld_q, pend_vld_d;
  logic signed [WIDTH-1:0]  pend_q, pend_d;
  logic                     neg_q, neg_d;
  logic                     done_q, done_d;
  logic [DIGITS*8-1:0]      fmt_q, fmt_d;
  logic [CW-1:0]            blink_cnt_q, blink_cnt_d;
  logic                     phase_q, phase_d;

  logic                     start;
  logic signed [WIDTH-1:0]  start_val;
  logic [WIDTH-1:0]         start_mag;
  logic                     conv_busy, conv_done;
  logic [NBCD*4-1:0]        conv_bcd;

  logic [NPAD*4-1:0]        bcd_pad;
  logic                     ovf;
  int                       msd;
  byte_t                    glyph;
  logic [DIGITS*8-1:0]      fmt_word;

  bcd_seq_conv #(
    .WIDTH (WIDTH),
    .NBCD  (NBCD)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (start_mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
  assign start_mag = start_val[WIDTH-1] ? $unsigned(-start_val) : $unsigned(start_val);

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    fmt_d      = fmt_q;
    start      = 1'b0;
    start_val  = value;
    case (state_q)
      S_IDLE: begin
        if (value_valid) begin
          start   = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (value_valid) begin
          pend_vld_d = 1'b1;
          pend_d     = value;
        end
        if (conv_done) state_d = S_FMT;
      end
      S_FMT: begin
        fmt_d  = fmt_word;
        done_d = 1'b1;
        if (pend_vld_q) begin
          // Chain straight into the pending request; a request arriving now
          // refills the slot just vacated.
          start      = 1'b1;
          start_val  = pend_q;
          state_d    = S_CONV;
          pend_vld_d = value_valid;
          if (value_valid) pend_d = value;
        end else if (value_valid) begin
          start   = 1'b1;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start) neg_d = start_val[WIDTH-1];
  end

  always_comb begin
    bcd_pad              = '0;
    bcd_pad[NBCD*4-1:0]  = conv_bcd;
    ovf                  = 1'b0;
    for (int i = DIGITS; i < NPAD; i++) begin
      if (bcd_pad[i*4 +: 4] != 4'd0) ovf = 1'b1;
    end
    // A negative value needs the top digit free for the minus sign.
    if (neg_q && (bcd_pad[(DIGITS-1)*4 +: 4] != 4'd0)) ovf = 1'b1;

    msd = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_pad[i*4 +: 4] != 4'd0) msd = i;
    end

    fmt_word = {DIGITS{SEG_BLANK}};
    glyph    = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      glyph = dec_cat_map(bcd_pad[i*4 +: 4]);
      if (ovf) begin
        fmt_word[i*8 +: 8] = (i == 0) ? SEG_E : SEG_BLANK;
      end else if (blank_lz) begin
        if (i <= msd)                    fmt_word[i*8 +: 8] = glyph;
        else if (neg_q && i == msd + 1)  fmt_word[i*8 +: 8] = SEG_MINUS;
        else                             fmt_word[i*8 +: 8] = SEG_BLANK;
      end else begin
        fmt_word[i*8 +: 8] = (neg_q && i == DIGITS - 1) ? SEG_MINUS : glyph;
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_vld_q  <= 1'b0;
      done_q      <= 1'b0;
      fmt_q       <= {DIGITS{SEG_BLANK}};
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      done_q      <= done_d;
      fmt_q       <= fmt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    neg_q  <= neg_d;
  end

  // Blink overlay sits after the register so it never disturbs the stored result.
  always_comb begin
    display = fmt_q;
    if (is_edit && phase_q) display[{edit_pos, 3'b000} +: 8] = SEG_BLANK;
  end

  assign busy = (state_q != S_IDLE) || conv_busy;
  assign done = done_q;

endmodule

// File: tb/tb_seg_display_fmt.sv
module tb_seg_display_fmt;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] value;
  logic               value_valid;
  logic               is_edit;
  logic [2:0]         edit_pos;
  logic               blank_lz;
  logic [63:0]        display;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;
  int since_rst = 0;

  logic signed [31:0] rng_val [5];
  logic [63:0]        rng_exp [5];

  seg_display_fmt #(
    .DIGITS    (8),
    .WIDTH     (32),
    .BLINK_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .is_edit     (is_edit),
    .edit_pos    (edit_pos),
    .blank_lz    (blank_lz),
    .display     (display),
    .busy        (busy),
    .done        (done)
  );

  initial forever #5 clk = ~clk;

  // Edges elapsed since the last reset edge, for the blink-phase expectation.
  always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic signed [31:0] v, output int lat);
    value       = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; value = '0; value_valid = 1'b0; is_edit = 1'b0;
    edit_pos = '0; blank_lz = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (display !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL reset_display got=%h exp=%h", display, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_basic();
    int lat;
    blank_lz    = 1'b1;
    value       = 32'sd1234;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 34) begin failures++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    checks++;
    if (display !== 64'hFFFF_FFFF_F9A4_B099) begin
      failures++; $display("FAIL basic_1234 got=%h exp=%h", display, 64'hFFFF_FFFF_F9A4_B099);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_sign();
    int lat;
    blank_lz = 1'b1;
    convert(-32'sd56, lat);
    checks++;
    if (display !== 64'hFFFF_FFFF_FFBF_9282) begin
      failures++; $display("FAIL sign_neg56_blz got=%h exp=%h", display, 64'hFFFF_FFFF_FFBF_9282);
    end
    convert(32'sd0, lat);
    checks++;
    if (display !== 64'hFFFF_FFFF_FFFF_FFC0) begin
      failures++; $display("FAIL sign_zero got=%h exp=%h", display, 64'hFFFF_FFFF_FFFF_FFC0);
    end
    blank_lz = 1'b0;
    convert(-32'sd56, lat);
    checks++;
    if (display !== 64'hBFC0_C0C0_C0C0_9282) begin
      failures++; $display("FAIL sign_neg56_noblz got=%h exp=%h", display, 64'hBFC0_C0C0_C0C0_9282);
    end
    checks++;
    if (lat != 34) begin failures++; $display("FAIL sign_latency got=%0d exp=34", lat); end
    blank_lz = 1'b1;
  endtask

  task automatic test_range();
    int lat;
    blank_lz = 1'b1;
    rng_val[0] = 32'sd99999999;   rng_exp[0] = 64'h9090_9090_9090_9090;
    rng_val[1] = 32'sd100000000;  rng_exp[1] = 64'hFFFF_FFFF_FFFF_FF86;
    rng_val[2] = -32'sd9999999;   rng_exp[2] = 64'hBF90_9090_9090_9090;
    rng_val[3] = -32'sd10000000;  rng_exp[3] = 64'hFFFF_FFFF_FFFF_FF86;
    rng_val[4] = 32'sh8000_0000;  rng_exp[4] = 64'hFFFF_FFFF_FFFF_FF86;
    for (int i = 0; i < 5; i++) begin
      convert(rng_val[i], lat);
      checks++;
      if (display !== rng_exp[i] || lat != 34) begin
        failures++;
        $display("FAIL range_%0d value=%0d got=%h lat=%0d exp=%h lat=34",
                 i, rng_val[i], display, lat, rng_exp[i]);
      end
    end
  endtask

  task automatic test_blank_hold();
    int lat;
    blank_lz = 1'b1;
    convert(32'sd1234, lat);
    blank_lz = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (display !== 64'hFFFF_FFFF_F9A4_B099) begin
      failures++; $display("FAIL blank_hold got=%h exp=%h", display, 64'hFFFF_FFFF_F9A4_B099);
    end
    blank_lz = 1'b1;
  endtask

  task automatic test_edit();
    int lat;
    int nblank;
    int nglyph;
    logic [63:0] expv;
    blank_lz = 1'b1;
    convert(32'sd1234, lat);
    is_edit  = 1'b1;
    edit_pos = 3'd2;
    nblank = 0;
    nglyph = 0;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (((since_rst / 4) % 2) == 1) begin
        expv = 64'hFFFF_FFFF_F9FF_B099;
        nblank++;
      end else begin
        expv = 64'hFFFF_FFFF_F9A4_B099;
        nglyph++;
      end
      checks++;
      if (display !== expv) begin
        failures++; $display("FAIL edit_blink_%0d got=%h exp=%h", j, display, expv);
      end
    end
    checks++;
    if (nblank != 8 || nglyph != 8) begin
      failures++; $display("FAIL edit_duty got blank=%0d glyph=%0d exp 8/8", nblank, nglyph);
    end
    is_edit = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++;
      if (display !== 64'hFFFF_FFFF_F9A4_B099) begin
        failures++; $display("FAIL edit_off_%0d got=%h exp=%h", j, display, 64'hFFFF_FFFF_F9A4_B099);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int idle_cyc;
    int d1;
    int d2;
    logic [63:0] disp1;
    logic [63:0] disp2;
    blank_lz = 1'b1;
    value = 32'sd11; value_valid = 1'b1;
    tick();
    value = 32'sd22;
    tick();
    value = 32'sd33;
    tick();
    value_valid = 1'b0;
    ndone = 0; idle_cyc = 0; d1 = -1; d2 = -1; disp1 = '0; disp2 = '0;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin d1 = j; disp1 = display; end
        else if (ndone == 2) begin d2 = j; disp2 = display; end
      end
      if (ndone < 2 && busy !== 1'b1) idle_cyc++;
    end
    checks++;
    if (ndone != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
    checks++;
    if (d1 != 32 || d2 != 66) begin
      failures++; $display("FAIL b2b_done_times got=%0d,%0d exp=32,66", d1, d2);
    end
    checks++;
    if (disp1 !== 64'hFFFF_FFFF_FFFF_F9F9) begin
      failures++; $display("FAIL b2b_first got=%h exp=%h", disp1, 64'hFFFF_FFFF_FFFF_F9F9);
    end
    checks++;
    if (disp2 !== 64'hFFFF_FFFF_FFFF_B0B0) begin
      failures++; $display("FAIL b2b_second got=%h exp=%h", disp2, 64'hFFFF_FFFF_FFFF_B0B0);
    end
    checks++;
    if (idle_cyc != 0) begin failures++; $display("FAIL b2b_busy_gap got=%0d exp=0", idle_cyc); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    blank_lz = 1'b1;
    value = 32'sd1234; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (display !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL rstmid_display got=%h exp=%h", display, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    ndone = 0;
    for (int j = 0; j < 50; j++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_reset_valid();
    int ndone;
    rst = 1'b1; value = 32'sd5; value_valid = 1'b1;
    tick();
    rst = 1'b0; value_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstvalid_busy got=%b exp=0", busy); end
    ndone = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || display !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL rstvalid_ignored got done=%0d disp=%h exp done=0 disp=%h",
                           ndone, display, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_range();
    test_blank_hold();
    test_edit();
    test_back_to_back();
    test_reset_mid();
    test_reset_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
